// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller and its RAM dump sequencer.
package cpu_run_ctrl_pkg;

  localparam int CNT_W     = 16;
  localparam int RST_CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_RUN       = 3'd2,
    S_DUMP_RD   = 3'd3,
    S_DUMP_WAIT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HALT    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ABORT   = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    DP_IDLE = 2'b00,
    DP_RD   = 2'b01,
    DP_WAIT = 2'b10
  } dump_phase_t;

  // Widened increment so the terminal-count compare cannot overflow at 16'hFFFF.
  function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_dump_seq.sv
// Data-RAM dump sequencer: walks DUMP_LEN words from DUMP_BASE through the debug port
// and presents each one on a registered valid/ready stage.
module mem_dump_seq
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 10,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_dump,
  input  logic              abort,
  output logic              dbg_en,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DUMP_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D    = {DATA_W{1'b0}};

  dump_phase_t       phase_r;
  logic [ADDR_W-1:0] idx_r;
  logic              last_s;

  // Last-word detect and the accept strobe that ends the dump.
  always_comb begin
    last_s    = (idx_r == LAST_IDX);
    dump_done = 1'b0;
    if (phase_r == DP_WAIT && dump_ready && !abort) begin
      dump_done = last_s;
    end else begin
      dump_done = 1'b0;
    end
  end

  // Read/present sequencing; dbg_addr advances in step with idx and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r    <= DP_IDLE;
      idx_r      <= ZERO_A;
      dbg_en     <= 1'b0;
      dbg_addr   <= BASE_ADDR;
      dump_valid <= 1'b0;
      dump_addr  <= ZERO_A;
      dump_data  <= ZERO_D;
    end else if (abort && phase_r != DP_IDLE) begin
      phase_r    <= DP_IDLE;
      idx_r      <= ZERO_A;
      dbg_en     <= 1'b0;
      dbg_addr   <= BASE_ADDR;
      dump_valid <= 1'b0;
    end else begin
      case (phase_r)
        DP_IDLE: begin
          if (start_dump) begin
            phase_r  <= DP_RD;
            idx_r    <= ZERO_A;
            dbg_en   <= 1'b1;
            dbg_addr <= BASE_ADDR;
          end else begin
            phase_r  <= DP_IDLE;
          end
        end
        DP_RD: begin
          dump_data  <= dbg_rdata;
          dump_addr  <= dbg_addr;
          dump_valid <= 1'b1;
          phase_r    <= DP_WAIT;
        end
        DP_WAIT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (last_s) begin
              phase_r  <= DP_IDLE;
              idx_r    <= ZERO_A;
              dbg_en   <= 1'b0;
              dbg_addr <= BASE_ADDR;
            end else begin
              phase_r  <= DP_RD;
              idx_r    <= idx_r + ONE_A;
              dbg_addr <= dbg_addr + ONE_A;
            end
          end else begin
            phase_r <= DP_WAIT;
          end
        end
        default: begin
          phase_r    <= DP_IDLE;
          idx_r      <= ZERO_A;
          dbg_en     <= 1'b0;
          dbg_addr   <= BASE_ADDR;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 10-bit pipelined CPU: reset hold, budgeted run, and a
// post-run data-RAM dump over valid/ready.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int ADDR_W     = 10,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1000,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_LEN   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cpu_halted,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              dbg_en,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready
);

  localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CYCLES[RST_CNT_W-1:0];
  localparam logic [CNT_W:0]       MAX_CNT  = MAX_CYCLES[CNT_W:0];

  state_t                 state_r;
  logic [RST_CNT_W-1:0]   rst_cnt_r;
  logic [CNT_W:0]         run_next_s;
  logic                   timeout_s;
  logic                   start_dump_s;
  logic                   dump_done_s;

  // RUN exit decode: abort outranks halt, halt outranks the cycle budget.
  always_comb begin
    run_next_s   = cnt_inc(cycle_count);
    timeout_s    = (run_next_s == MAX_CNT);
    start_dump_s = 1'b0;
    if (state_r == S_RUN && !abort) begin
      start_dump_s = cpu_halted || timeout_s;
    end else begin
      start_dump_s = 1'b0;
    end
  end

  // Main sequencing FSM with registered CPU controls, status and cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      rst_cnt_r   <= 4'd0;
      cpu_rst     <= 1'b1;
      cpu_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_NONE;
      cycle_count <= {CNT_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
          if (start) begin
            state_r     <= S_RST_HOLD;
            rst_cnt_r   <= RST_LOAD;
            cycle_count <= {CNT_W{1'b0}};
            status      <= ST_NONE;
            busy        <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_RST_HOLD: begin
          if (abort) begin
            state_r <= S_DONE;
            status  <= ST_ABORT;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else if (rst_cnt_r <= 4'd1) begin
            state_r <= S_RUN;
            cpu_rst <= 1'b0;
            cpu_en  <= 1'b1;
          end else begin
            rst_cnt_r <= rst_cnt_r - 4'd1;
          end
        end
        S_RUN: begin
          // The exit cycle is itself a RUN cycle and is counted.
          cycle_count <= run_next_s[CNT_W-1:0];
          if (abort) begin
            state_r <= S_DONE;
            status  <= ST_ABORT;
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_en  <= 1'b0;
            cpu_rst <= 1'b1;
          end else if (cpu_halted) begin
            state_r <= S_DUMP_RD;
            status  <= ST_HALT;
            cpu_en  <= 1'b0;
          end else if (timeout_s) begin
            state_r <= S_DUMP_RD;
            status  <= ST_TIMEOUT;
            cpu_en  <= 1'b0;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_DUMP_RD: begin
          if (abort) begin
            state_r <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_rst <= 1'b1;
          end else begin
            state_r <= S_DUMP_WAIT;
          end
        end
        S_DUMP_WAIT: begin
          if (abort || dump_done_s) begin
            state_r <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_rst <= 1'b1;
          end else if (dump_ready) begin
            state_r <= S_DUMP_RD;
          end else begin
            state_r <= S_DUMP_WAIT;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
        end
      endcase
    end
  end

  mem_dump_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LEN  (DUMP_LEN)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .start_dump (start_dump_s),
    .abort      (abort),
    .dbg_en     (dbg_en),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_ready (dump_ready),
    .dump_done  (dump_done_s)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a main instance (50-cycle budget, 16 words from 0) and a
// wrap instance (16'd1000 budget, 4 words from 1022), checked against a run-level model.
module tb_cpu_run_ctrl;

  localparam int NU     = 2;
  localparam int A_MAX  = 50;
  localparam int A_BASE = 0;
  localparam int A_LEN  = 16;
  localparam int W_MAX  = 1000;
  localparam int W_BASE = 1022;
  localparam int W_LEN  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [NU];
  logic        abort [NU];
  logic        halted [NU];
  logic        ready [NU];
  logic        cpu_rst [NU];
  logic        cpu_en [NU];
  logic        busy [NU];
  logic        done [NU];
  logic        dbg_en [NU];
  logic        dump_valid [NU];
  logic [1:0]  status [NU];
  logic [15:0] cycle_count [NU];
  logic [9:0]  dbg_addr [NU];
  logic [9:0]  dbg_rdata [NU];
  logic [9:0]  dump_addr [NU];
  logic [9:0]  dump_data [NU];
  logic [9:0]  ram [1024];

  int n_cmp  = 0;
  int n_fail = 0;

  assign dbg_rdata[0] = ram[dbg_addr[0]];
  assign dbg_rdata[1] = ram[dbg_addr[1]];

  cpu_run_ctrl #(.DATA_W(10), .ADDR_W(10), .RST_CYCLES(2), .MAX_CYCLES(A_MAX),
                 .DUMP_BASE(A_BASE), .DUMP_LEN(A_LEN)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .cpu_halted(halted[0]),
    .cpu_rst(cpu_rst[0]), .cpu_en(cpu_en[0]), .busy(busy[0]), .done(done[0]),
    .status(status[0]), .cycle_count(cycle_count[0]), .dbg_en(dbg_en[0]),
    .dbg_addr(dbg_addr[0]), .dbg_rdata(dbg_rdata[0]), .dump_valid(dump_valid[0]),
    .dump_addr(dump_addr[0]), .dump_data(dump_data[0]), .dump_ready(ready[0]));

  cpu_run_ctrl #(.DATA_W(10), .ADDR_W(10), .RST_CYCLES(2), .MAX_CYCLES(W_MAX),
                 .DUMP_BASE(W_BASE), .DUMP_LEN(W_LEN)) dut_w (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .cpu_halted(halted[1]),
    .cpu_rst(cpu_rst[1]), .cpu_en(cpu_en[1]), .busy(busy[1]), .done(done[1]),
    .status(status[1]), .cycle_count(cycle_count[1]), .dbg_en(dbg_en[1]),
    .dbg_addr(dbg_addr[1]), .dbg_rdata(dbg_rdata[1]), .dump_valid(dump_valid[1]),
    .dump_addr(dump_addr[1]), .dump_data(dump_data[1]), .dump_ready(ready[1]));

  function automatic int maxc(input int u);
    return (u == 0) ? A_MAX : W_MAX;
  endfunction
  function automatic int dbase(input int u);
    return (u == 0) ? A_BASE : W_BASE;
  endfunction
  function automatic int dlen(input int u);
    return (u == 0) ? A_LEN : W_LEN;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run-level outcome: which exit wins, the final count, and how many words get accepted.
  task automatic model(input int u, input int halt_at, input int abort_at, input int abort_word,
                       output int e_status, output int e_count, output int e_words);
    int mc;
    mc = maxc(u);
    if (abort_at > 0 && abort_at <= mc && (halt_at == 0 || abort_at <= halt_at)) begin
      e_status = 3; e_count = abort_at; e_words = 0;
    end else begin
      if (halt_at > 0 && halt_at <= mc) begin
        e_status = 1; e_count = halt_at;
      end else begin
        e_status = 2; e_count = mc;
      end
      e_words = (abort_word >= 0 && abort_word < dlen(u)) ? abort_word : dlen(u);
    end
  endtask

  task automatic chk_reset(input int u, input string nm);
    chk({nm, " rst.cpu_rst"}, cpu_rst[u], 1);
    chk({nm, " rst.cpu_en"}, cpu_en[u], 0);
    chk({nm, " rst.busy"}, busy[u], 0);
    chk({nm, " rst.done"}, done[u], 0);
    chk({nm, " rst.status"}, status[u], 0);
    chk({nm, " rst.cycle_count"}, cycle_count[u], 0);
    chk({nm, " rst.dbg_en"}, dbg_en[u], 0);
    chk({nm, " rst.dbg_addr"}, dbg_addr[u], dbase(u));
    chk({nm, " rst.dump_valid"}, dump_valid[u], 0);
    chk({nm, " rst.dump_addr"}, dump_addr[u], 0);
    chk({nm, " rst.dump_data"}, dump_data[u], 0);
  endtask

  // ready_mode: 0 always ready, 1 two stalls then accept per word, 2 random.
  task automatic do_run(input int u, input string nm, input int halt_at, input int abort_at,
                        input int abort_word, input int rst_word, input int ready_mode,
                        input bit start_busy);
    int e_status, e_count, e_words, hold, k, n, cyc, stall, ea;
    bit stalled, aborted;
    logic [9:0] p_addr, p_data;
    model(u, halt_at, abort_at, abort_word, e_status, e_count, e_words);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    chk({nm, " busy_after_start"}, busy[u], 1);
    hold = 0;
    while (cpu_rst[u] && !cpu_en[u] && hold < 20) begin
      hold++;
      tick();
    end
    chk({nm, " rst_hold_cycles"}, hold, 2);
    chk({nm, " run_cpu_rst"}, cpu_rst[u], 0);
    k = 0;
    while (cpu_en[u] && k < 1100) begin
      k++;
      halted[u] = (halt_at > 0 && k >= halt_at);
      abort[u]  = (k == abort_at);
      start[u]  = (start_busy && k == 3);
      tick();
    end
    abort[u] = 1'b0; start[u] = 1'b0; halted[u] = 1'b0;
    chk({nm, " cpu_en_cycles"}, k, e_count);
    chk({nm, " cycle_count"}, cycle_count[u], e_count);
    chk({nm, " status"}, status[u], e_status);
    n = 0; cyc = 0; stall = 0; stalled = 1'b0; aborted = 1'b0;
    p_addr = 10'd0; p_data = 10'd0;
    while (!done[u] && cyc < 400) begin
      ea = (dbase(u) + n) % 1024;
      if (stalled) begin
        chk({nm, " hold_valid"}, dump_valid[u], 1);
        chk({nm, " hold_addr"}, dump_addr[u], p_addr);
        chk({nm, " hold_data"}, dump_data[u], p_data);
      end else if (!dump_valid[u]) begin
        chk({nm, " dbg_en"}, dbg_en[u], 1);
        chk({nm, " dbg_addr"}, dbg_addr[u], ea);
      end
      if (ready_mode == 0) begin
        ready[u] = 1'b1;
      end else if (ready_mode == 1) begin
        ready[u] = dump_valid[u] && (stall == 2);
        if (dump_valid[u]) stall = (stall == 2) ? 0 : stall + 1;
      end else begin
        ready[u] = 1'($urandom_range(0, 1));
      end
      if (rst_word == n && dump_valid[u]) begin
        rst = 1'b1; ready[u] = 1'b0;
        tick();
        rst = 1'b0;
        chk_reset(u, nm);
        return;
      end
      if (abort_word == n && !aborted) begin
        abort[u] = 1'b1; ready[u] = 1'b0; aborted = 1'b1;
      end else if (dump_valid[u] && ready[u]) begin
        chk({nm, " dump_addr"}, dump_addr[u], ea);
        chk({nm, " dump_data"}, dump_data[u], ram[ea]);
        n++;
      end
      stalled = dump_valid[u] && !ready[u] && !abort[u];
      p_addr = dump_addr[u];
      p_data = dump_data[u];
      tick();
      abort[u] = 1'b0;
      cyc++;
    end
    ready[u] = 1'b0;
    chk({nm, " words"}, n, e_words);
    if (ready_mode == 0 && abort_word < 0 && e_words > 0) chk({nm, " dump_cycles"}, cyc, 2 * e_words);
    chk({nm, " done_pulse"}, done[u], 1);
    chk({nm, " busy_in_done"}, busy[u], 0);
    chk({nm, " dump_valid_off"}, dump_valid[u], 0);
    chk({nm, " dbg_en_off"}, dbg_en[u], 0);
    chk({nm, " status_final"}, status[u], e_status);
    chk({nm, " count_final"}, cycle_count[u], e_count);
    tick();
    chk({nm, " done_one_cycle"}, done[u], 0);
    chk({nm, " idle_cpu_rst"}, cpu_rst[u], 1);
    chk({nm, " status_kept"}, status[u], e_status);
    chk({nm, " count_kept"}, cycle_count[u], e_count);
  endtask

  task automatic abort_hold(input int u);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    abort[u] = 1'b1;
    tick();
    abort[u] = 1'b0;
    chk("abort_hold done", done[u], 1);
    chk("abort_hold status", status[u], 3);
    chk("abort_hold busy", busy[u], 0);
    chk("abort_hold cpu_en", cpu_en[u], 0);
    chk("abort_hold count", cycle_count[u], 0);
    tick();
    chk("abort_hold done_clear", done[u], 0);
    chk("abort_hold status_kept", status[u], 3);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 10'($urandom);
    for (int u = 0; u < NU; u++) begin
      start[u] = 1'b0; abort[u] = 1'b0; halted[u] = 1'b0; ready[u] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    chk_reset(0, "init_a");
    chk_reset(1, "init_w");
    rst = 1'b0;
    tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("idle_abort busy", busy[0], 0);
    chk("idle_abort done", done[0], 0);
    chk("idle_abort cpu_rst", cpu_rst[0], 1);

    do_run(0, "halt", 37, 0, -1, -1, 0, 1'b0);
    do_run(0, "timeout", 0, 0, -1, -1, 0, 1'b0);
    do_run(0, "backpressure", $urandom_range(1, 49), 0, -1, -1, 1, 1'b0);
    do_run(0, "abort_halt", 20, 20, -1, -1, 0, 1'b0);
    abort_hold(0);
    do_run(0, "abort_dump", 12, 0, 7, -1, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_run(0, "random", $urandom_range(0, 60), 0, -1, -1, 2, 1'b0);
    end
    do_run(0, "rst_mid", 10, 0, -1, 5, 0, 1'b1);
    tick();
    do_run(1, "wrap", $urandom_range(1, 30), 0, -1, -1, 2, 1'b0);
    do_run(1, "wrap_full", $urandom_range(1, 30), 0, -1, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
